// File: rtl/nb_iter_decoder_if.sv
// nb_iter_decoder_if
//   Bundles the request/result signals of nb_iter_decoder.
//   master: drives start, a_in, b_in, c_in, d_in, cnt (and dir when
//           NB_ITER_FWD_EN is defined); observes busy, done, a_out, b_out, d_out.
//   slave : the decoder side, with the directions reversed.
//   Parameters WIDTH / CNT_W must match the decoder instance.
//   Optional feature macro: NB_ITER_FWD_EN (adds the dir signal).
interface nb_iter_decoder_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] c_in;
    logic [WIDTH-1:0] d_in;
    logic [CNT_W-1:0] cnt;
`ifdef NB_ITER_FWD_EN
    logic             dir;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] d_out;

    modport master (
`ifdef NB_ITER_FWD_EN
        output dir,
`endif
        output start, a_in, b_in, c_in, d_in, cnt,
        input  busy, done, a_out, b_out, d_out
    );

    modport slave (
`ifdef NB_ITER_FWD_EN
        input  dir,
`endif
        input  start, a_in, b_in, c_in, d_in, cnt,
        output busy, done, a_out, b_out, d_out
    );
endinterface

// File: rtl/nb_iter_decoder.sv
// nb_iter_decoder
//   Undoes the feedback iteration a<=b+c; d<=a-K_SUB; b<=d+K_ADD, one step per
//   clock, recovering the original (a,b,d) from the final values, c and count.
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous, active-high reset (priority over start)
//     bus.slave start/a_in/b_in/c_in/d_in/cnt in; busy/done/a_out/b_out/d_out out
//   FSM IDLE -> RUN (cnt steps) -> DONE (one cycle) -> IDLE; start accepted in
//   IDLE or DONE, ignored in RUN. Arithmetic wraps modulo 2^WIDTH.
//   Optional feature macro: NB_ITER_FWD_EN -- adds bus.dir, sampled with start;
//   dir=1 runs the forward update instead of the inverse, same timing.
module nb_iter_decoder #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 4,
    parameter int K_SUB = 3,
    parameter int K_ADD = 10
) (
    input  logic              clk,
    input  logic              rst,
    nb_iter_decoder_if.slave  bus
);

    localparam logic [WIDTH-1:0] LP_KSUB = WIDTH'(K_SUB);
    localparam logic [WIDTH-1:0] LP_KADD = WIDTH'(K_ADD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_c;
    logic [CNT_W-1:0] r_rem;
    logic             r_busy;
    logic             r_done;
`ifdef NB_ITER_FWD_EN
    logic             r_dir;
`endif

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.a_out = r_a;
    assign bus.b_out = r_b;
    assign bus.d_out = r_d;

    // busy/done are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_c     <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef NB_ITER_FWD_EN
            r_dir   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_RUN: begin
`ifdef NB_ITER_FWD_EN
                    if (r_dir) begin
                        r_a <= r_b + r_c;
                        r_d <= r_a - LP_KSUB;
                        r_b <= r_d + LP_KADD;
                    end else begin
                        r_b <= r_a - r_c;
                        r_a <= r_d + LP_KSUB;
                        r_d <= r_b - LP_KADD;
                    end
`else
                    r_b <= r_a - r_c;
                    r_a <= r_d + LP_KSUB;
                    r_d <= r_b - LP_KADD;
`endif
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; accepting in DONE gives back-to-back runs.
                    if (bus.start) begin
                        r_a   <= bus.a_in;
                        r_b   <= bus.b_in;
                        r_d   <= bus.d_in;
                        r_c   <= bus.c_in;
                        r_rem <= bus.cnt;
`ifdef NB_ITER_FWD_EN
                        r_dir <= bus.dir;
`endif
                        if (bus.cnt == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nb_iter_decoder.sv
// tb_nb_iter_decoder
//   Directed bench for nb_iter_decoder: expected results are pushed to a queue
//   when a request is accepted and popped when done pulses.
//   Optional feature macro: NB_ITER_FWD_EN (enables the dir-port scenario).
module tb_nb_iter_decoder;

    localparam int W  = 32;
    localparam int CW = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        int           lat;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    res_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    nb_iter_decoder_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    nb_iter_decoder #(
        .WIDTH(W),
        .CNT_W(CW),
        .K_SUB(3),
        .K_ADD(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Forward iteration reference, used to build round-trip inputs.
    task automatic fwd(input int n, inout logic [W-1:0] a, inout logic [W-1:0] b,
                       inout logic [W-1:0] d, input logic [W-1:0] c);
        logic [W-1:0] na, nb, nd;
        for (int i = 0; i < n; i++) begin
            na = b + c;
            nd = a - 32'd3;
            nb = d + 32'd10;
            a = na; b = nb; d = nd;
        end
    endtask

    // Drive one request at a negedge; the following posedge accepts it.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [W-1:0] d, input logic [CW-1:0] n, input logic dr);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.c_in  = c;
        bus.d_in  = d;
        bus.cnt   = n;
`ifdef NB_ITER_FWD_EN
        bus.dir   = dr;
`else
        if (dr) $display("note: dir ignored in this build");
`endif
    endtask

    task automatic scramble();
        bus.start = 1'b0;
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
        bus.c_in  = $urandom;
        bus.d_in  = $urandom;
        bus.cnt   = CW'($urandom);
    endtask

    // Called at the negedge right after the accepting edge (elapsed cycles = 0 there).
    task automatic wait_done(input string tag, input int elapsed);
        int   lat;
        logic saw_busy;
        res_t e;
        lat = elapsed;
        saw_busy = 1'b0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) saw_busy = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, W'(lat), W'(e.lat));
        check({tag, "_busy"}, W'(saw_busy), W'(e.lat != 0));
        check({tag, "_a"}, bus.a_out, e.a);
        check({tag, "_b"}, bus.b_out, e.b);
        check({tag, "_d"}, bus.d_out, e.d);
    endtask

    initial begin
        logic [W-1:0] xa, xb, xd, xc, ha;
        logic         saw_done;

        rst = 1'b1;
        scramble();
`ifdef NB_ITER_FWD_EN
        bus.dir = 1'b0;
`endif
        repeat (3) @(negedge clk);
        bus.start = 1'b1;            // rst must win over start
        @(negedge clk);
        check("rst_a", bus.a_out, '0);
        check("rst_b", bus.b_out, '0);
        check("rst_d", bus.d_out, '0);
        check("rst_busy", W'(bus.busy), '0);
        check("rst_done", W'(bus.done), '0);
        rst = 1'b0;
        scramble();
        @(negedge clk);

        // Case 1: cnt=4
        drive(57, 37, 15, 49, 4, 1'b0);
        sb.push_back('{a: 30, b: 20, d: 5, lat: 4});
        @(negedge clk); scramble();
        wait_done("c1", 0);

        // Outputs hold in IDLE with garbage on inputs
        ha = bus.a_out;
        repeat (2) @(negedge clk);
        check("hold_a", bus.a_out, 32'd30);
        check("hold_idle_done", W'(bus.done), '0);

        // Case 2: cnt=0
        drive(7, 8, 99, 9, 0, 1'b0);
        sb.push_back('{a: 7, b: 8, d: 9, lat: 0});
        @(negedge clk); scramble();
        wait_done("c2", 0);
        @(negedge clk);

        // Case 3: wrap
        drive(0, 0, 15, 0, 1, 1'b0);
        sb.push_back('{a: 3, b: 32'hFFFF_FFF1, d: 32'hFFFF_FFF6, lat: 1});
        @(negedge clk); scramble();
        wait_done("c3", 0);
        @(negedge clk);

        // Case 4a: start during RUN ignored
        drive(57, 37, 15, 49, 4, 1'b0);
        sb.push_back('{a: 30, b: 20, d: 5, lat: 4});
        @(negedge clk);
        drive(1, 2, 3, 4, 2, 1'b0);
        @(negedge clk); scramble();
        wait_done("c4_ign", 1);

        // Case 4b: start in DONE, no idle gap
        drive(0, 0, 15, 0, 1, 1'b0);
        sb.push_back('{a: 3, b: 32'hFFFF_FFF1, d: 32'hFFFF_FFF6, lat: 1});
        @(negedge clk); scramble();
        check("b2b_busy", W'(bus.busy), W'(1));
        wait_done("c4_b2b", 0);
        @(negedge clk);

        // Round trip on random data
        xa = $urandom; xb = $urandom; xd = $urandom; xc = $urandom;
        begin
            logic [W-1:0] ya, yb, yd;
            ya = xa; yb = xb; yd = xd;
            fwd(9, ya, yb, yd, xc);
            drive(ya, yb, xc, yd, 9, 1'b0);
        end
        sb.push_back('{a: xa, b: xb, d: xd, lat: 9});
        @(negedge clk); scramble();
        wait_done("rtrip", 0);
        @(negedge clk);

        // Case 5: reset aborts a run
        drive(57, 37, 15, 49, 4, 1'b0);
        @(negedge clk); scramble();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_a", bus.a_out, '0);
        check("abort_b", bus.b_out, '0);
        check("abort_d", bus.d_out, '0);
        check("abort_busy", W'(bus.busy), '0);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort_nodone", W'(saw_done), '0);

`ifdef NB_ITER_FWD_EN
        // Case 6: forward then inverse
        drive(30, 20, 15, 5, 4, 1'b1);
        sb.push_back('{a: 57, b: 37, d: 49, lat: 4});
        @(negedge clk); scramble();
        wait_done("fwd", 0);
        drive(57, 37, 15, 49, 4, 1'b0);
        sb.push_back('{a: 30, b: 20, d: 5, lat: 4});
        @(negedge clk); scramble();
        wait_done("fwd_inv", 0);
`endif

        if (ha !== 32'd30) $display("note: held a value %h", ha);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
